// File: rtl/act_skew_feeder.sv
// Diagonal skew feeder for the systolic PE array: lane r delays its element by r cycles.
// Latency: a vector accepted at edge t shows on lane r in the cycle after edge t+r.
// Backpressure: in_ready drops after a tile's last vector until the skew pipe has drained.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready valid/ready handshake for one activation vector per cycle
//   in_data, in_last  packed lanes (lane r = bits [r*ACT_WIDTH +: ACT_WIDTH]); in_last closes a tile
//   act_out           skewed activations, same lane packing, feeds row r act_data_in
//   act_out_valid     per-lane flag: lane carries a real element (data is 0 otherwise)
//   tile_done         one-cycle pulse when a tile's last element leaves the bottom lane
//   tile_len          vector count of the most recently completed tile
module act_skew_feeder #(
  parameter int NUM_ROWS  = 4,
  parameter int ACT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_ROWS*ACT_WIDTH-1:0] in_data,
  input  logic                          in_last,
  output logic [NUM_ROWS*ACT_WIDTH-1:0] act_out,
  output logic [NUM_ROWS-1:0]           act_out_valid,
  output logic                          tile_done,
  output logic [CNT_WIDTH-1:0]          tile_len
);

  // flush_cnt only ever holds values up to NUM_ROWS-1.
  localparam int FC_W = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(NUM_ROWS - 1);

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } state_t;

  state_t               state;
  logic [FC_W-1:0]      flush_cnt;
  logic [CNT_WIDTH-1:0] vec_cnt;
  logic                 xfer;

  // Reset gates ready combinationally so nothing is taken while reset is held.
  assign in_ready = ~reset && (state == STREAM);
  assign xfer     = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Per-lane shift chains. Lane r owns r+1 registers; stage r is the output
  // register. Idle cycles push a zero bubble so invalid lanes always read 0.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    logic [ACT_WIDTH-1:0] stage_dat [0:r];
    logic [r:0]           stage_vld;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= r; k++) begin
          stage_dat[k] <= '0;
        end
        stage_vld <= '0;
      end else begin
        stage_dat[0] <= xfer ? in_data[r*ACT_WIDTH +: ACT_WIDTH] : '0;
        stage_vld[0] <= xfer;
        for (int k = 1; k <= r; k++) begin
          stage_dat[k] <= stage_dat[k-1];
          stage_vld[k] <= stage_vld[k-1];
        end
      end
    end

    assign act_out[r*ACT_WIDTH +: ACT_WIDTH] = stage_dat[r];
    assign act_out_valid[r]                  = stage_vld[r];
  end

  // ---------------------------------------------------------------------------
  // Tile control. After the last vector, FLUSH holds off input for NUM_ROWS-1
  // cycles. The edge that takes flush_cnt from 1 to 0 returns to STREAM and
  // raises tile_done, so the pulse, the restored in_ready and the last element
  // on the bottom lane all share one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STREAM;
      flush_cnt <= '0;
      vec_cnt   <= '0;
      tile_done <= 1'b0;
      tile_len  <= '0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        STREAM: begin
          if (xfer) begin
            // Wraps silently on overflow.
            vec_cnt <= vec_cnt + CNT_WIDTH'(1);
            if (in_last) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - FC_W'(1);
          if (flush_cnt == FC_W'(1)) begin
            state     <= STREAM;
            tile_done <= 1'b1;
            tile_len  <= vec_cnt;
            vec_cnt   <= '0;
          end
        end
        default: state <= STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
module tb_act_skew_feeder;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [N*AW-1:0] in_data;
  logic            in_last;
  logic [N*AW-1:0] act_out;
  logic [N-1:0]    act_out_valid;
  logic            tile_done;
  logic [CW-1:0]   tile_len;

  always #5 clk = ~clk;

  act_skew_feeder #(.NUM_ROWS(N), .ACT_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .act_out(act_out),
    .act_out_valid(act_out_valid), .tile_done(tile_done), .tile_len(tile_len)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: hist[k] is the vector accepted k edges ago (or a bubble).
  // Lane r simply shows hist[r]. Tile completion is scheduled N-1 edges after
  // the edge that accepted the last vector.
  logic [N*AW-1:0] h_dat [N];
  bit              h_vld [N];
  int              edge_no   = 0;
  bit              pending   = 1'b0;
  int              done_edge = 0;
  int              cnt       = 0;
  int              final_len = 0;
  logic [CW-1:0]   m_len     = '0;
  bit              m_done    = 1'b0;

  typedef struct {
    bit            rst;
    bit            v;
    bit            l;
    logic [31:0]   d;
    bit            rdy;
    logic [31:0]   act;
    logic [3:0]    vld;
    bit            done;
    logic [3:0]    len;
  } vec_t;

  vec_t tbl [12];
  vec_t none;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [N*AW-1:0] d, input bit l,
                      input bit tchk, input vec_t t);
    bit              m_ready;
    bit              acc;
    logic [N*AW-1:0] e_act;
    logic [N-1:0]    e_vld;
    reset    = rst;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    #1;
    m_ready = !rst && !(pending && edge_no < done_edge);
    check("in_ready", 32'(in_ready), 32'(m_ready));
    if (tchk) check("tbl_in_ready", 32'(in_ready), 32'(t.rdy));
    @(posedge clk);
    edge_no++;
    acc = m_ready && v;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        h_dat[k] = '0;
        h_vld[k] = 1'b0;
      end
      pending = 1'b0;
      cnt     = 0;
      m_len   = '0;
      m_done  = 1'b0;
    end else begin
      for (int k = N-1; k > 0; k--) begin
        h_dat[k] = h_dat[k-1];
        h_vld[k] = h_vld[k-1];
      end
      h_dat[0] = acc ? d : '0;
      h_vld[0] = acc;
      m_done = pending && (edge_no == done_edge);
      if (m_done) begin
        m_len   = CW'(final_len);
        pending = 1'b0;
      end
      if (acc) begin
        cnt++;
        if (l) begin
          pending   = 1'b1;
          done_edge = edge_no + N - 1;
          final_len = cnt % (1 << CW);
          cnt       = 0;
        end
      end
    end
    #1;
    for (int r = 0; r < N; r++) begin
      e_act[r*AW +: AW] = h_vld[r] ? h_dat[r][r*AW +: AW] : '0;
      e_vld[r]          = h_vld[r];
    end
    check("act_out", act_out, e_act);
    check("act_out_valid", 32'(act_out_valid), 32'(e_vld));
    check("tile_done", 32'(tile_done), 32'(m_done));
    check("tile_len", 32'(tile_len), 32'(m_len));
    if (tchk) begin
      check("tbl_act_out", act_out, t.act);
      check("tbl_act_out_valid", 32'(act_out_valid), 32'(t.vld));
      check("tbl_tile_done", 32'(tile_done), 32'(t.done));
      check("tbl_tile_len", 32'(tile_len), 32'(t.len));
    end
  endtask

  task automatic go(input bit v, input logic [N*AW-1:0] d, input bit l);
    step(1'b0, v, d, l, 1'b0, none);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, '0, 1'b0);
  endtask

  initial begin
    bit r_rst, r_v, r_l;
    for (int k = 0; k < N; k++) begin
      h_dat[k] = '0;
      h_vld[k] = 1'b0;
    end
    none = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 4'h0};
    // Reset with in_valid high, single-vector skew, held vector with in_last
    // during FLUSH taken exactly once, then its own one-vector tile.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h00000000, 4'h0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h00000000, 4'h0, 1'b0, 4'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h00000000, 4'h0, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hFF01807F, 1'b1, 32'h0000007F, 4'h1, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'h00008000, 4'h2, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'h00010000, 4'h4, 1'b0, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'hFF000000, 4'h8, 1'b1, 4'h1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 32'h00000078, 4'h1, 1'b0, 4'h1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00005600, 4'h2, 1'b0, 4'h1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00340000, 4'h4, 1'b0, 4'h1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h12000000, 4'h8, 1'b1, 4'h1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 4'h0, 1'b0, 4'h1};
    for (int i = 0; i < 12; i++) step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].l, 1'b1, tbl[i]);

    // Streaming with a 2-cycle gap after the 3rd vector, 6 vectors total.
    for (int i = 1; i <= 3; i++) go(1'b1, 32'h01010101 * i, 1'b0);
    idle(2);
    for (int i = 4; i <= 6; i++) go(1'b1, 32'h01010101 * i, i == 6);
    idle(N + 1);
    check("gap_tile_len", 32'(tile_len), 32'd6);

    // Reset one cycle after the last vector is accepted, then a 2-vector tile.
    go(1'b1, 32'hCAFEBABE, 1'b0);
    go(1'b1, 32'h80FF7F01, 1'b1);
    step(1'b1, 1'b1, 32'h55555555, 1'b0, 1'b0, none);
    idle(N + 1);
    go(1'b1, 32'h11223344, 1'b0);
    go(1'b1, 32'h99AABBCC, 1'b1);
    idle(N + 1);
    check("post_reset_tile_len", 32'(tile_len), 32'd2);

    // 17 vectors into a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) go(1'b1, $urandom, i == 16);
    idle(N + 1);
    check("wrap_tile_len", 32'(tile_len), 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(63) == 0);
      r_v   = ($urandom_range(9) < 7);
      r_l   = ($urandom_range(4) == 0);
      step(r_rst, r_v, $urandom, r_l, 1'b0, none);
    end
    idle(N + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
